// File: rtl/axi_lite_ram_slave.sv
// AXI4-Lite slave backed by a word-organised RAM. Independent write and read
// channels; reads return data after a programmable number of wait cycles.
module axi_lite_ram_slave #(
    parameter int          ADDR_WIDTH = 64,
    parameter int          DATA_WIDTH = 64,
    parameter logic [63:0] BASE_ADDR  = 64'h0,
    parameter int          MEM_BYTES  = 4096,
    parameter int          RD_LATENCY = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_WIDTH-1:0]     awaddr,
    input  logic [2:0]                awport,
    input  logic                      awvalid,
    output logic                      awready,
    input  logic [DATA_WIDTH-1:0]     wdata,
    input  logic [DATA_WIDTH/8-1:0]   wstrb,
    input  logic                      wvalid,
    output logic                      wready,
    output logic [1:0]                bresp,
    output logic                      bvalid,
    input  logic                      bready,
    input  logic [ADDR_WIDTH-1:0]     araddr,
    input  logic [2:0]                arport,
    input  logic                      arvalid,
    output logic                      arready,
    output logic [DATA_WIDTH-1:0]     rdata,
    output logic [1:0]                rresp,
    output logic                      rvalid,
    input  logic                      rready
);

    localparam int STRB_W   = DATA_WIDTH / 8;
    localparam int OFF_BITS = $clog2(STRB_W);
    localparam int WORDS    = MEM_BYTES / STRB_W;
    localparam int IDX_W    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [ADDR_WIDTH-1:0] BASE = BASE_ADDR[ADDR_WIDTH-1:0];
    localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'(MEM_BYTES);
    localparam logic [3:0] LAT = 4'(RD_LATENCY);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;

    // Subtract first so a base near the top of the address space cannot overflow.
    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return (a >= BASE) && ((a - BASE) < SPAN);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
        return IDX_W'((a - BASE) >> OFF_BITS);
    endfunction

    logic [DATA_WIDTH-1:0] mem [WORDS];

    w_state_t              w_state_q, w_state_d;
    logic                  aw_held_q, aw_held_d;
    logic                  w_held_q, w_held_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0]     wstrb_q, wstrb_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  ready_en_q;

    r_state_t              r_state_q, r_state_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  rvalid_q, rvalid_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic                  aw_fire, w_fire, ar_fire;
    logic                  wr_commit, rd_sample;
    logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [STRB_W-1:0]     wr_strb;

    logic unused_prot;
    assign unused_prot = ^{awport, arport};

    // ready_en_q holds the readies low until the first edge after reset release.
    assign awready = ready_en_q && (w_state_q == W_IDLE) && !aw_held_q;
    assign wready  = ready_en_q && (w_state_q == W_IDLE) && !w_held_q;
    assign arready = ready_en_q && (r_state_q == R_IDLE);
    assign aw_fire = awvalid && awready;
    assign w_fire  = wvalid && wready;
    assign ar_fire = arvalid && arready;

    assign bvalid = bvalid_q;
    assign bresp  = bresp_q;
    assign rvalid = rvalid_q;
    assign rresp  = rresp_q;
    assign rdata  = rdata_q;

    always_comb begin
        w_state_d = w_state_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        wr_commit = 1'b0;
        wr_addr   = aw_fire ? awaddr : awaddr_q;
        wr_data   = w_fire ? wdata : wdata_q;
        wr_strb   = w_fire ? wstrb : wstrb_q;
        case (w_state_q)
            W_IDLE: begin
                if (aw_fire) begin
                    aw_held_d = 1'b1;
                    awaddr_d  = awaddr;
                end
                if (w_fire) begin
                    w_held_d = 1'b1;
                    wdata_d  = wdata;
                    wstrb_d  = wstrb;
                end
                if ((aw_held_q || aw_fire) && (w_held_q || w_fire)) begin
                    wr_commit = 1'b1;
                    bresp_d   = in_range(wr_addr) ? RESP_OKAY : RESP_SLVERR;
                    bvalid_d  = 1'b1;
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (bready) begin
                    bvalid_d  = 1'b0;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        araddr_d  = araddr_q;
        cnt_d     = cnt_q;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        rd_sample = 1'b0;
        rd_addr   = araddr_q;
        case (r_state_q)
            R_IDLE: begin
                if (ar_fire) begin
                    araddr_d = araddr;
                    cnt_d    = LAT;
                    if (LAT == 4'd0) begin
                        rd_addr   = araddr;
                        rd_sample = 1'b1;
                    end else begin
                        r_state_d = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) rd_sample = 1'b1;
            end
            R_RESP: begin
                if (rready) begin
                    rvalid_d  = 1'b0;
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        // The array is read before this edge's write lands, so a same-edge hit sees old data.
        if (rd_sample) begin
            r_state_d = R_RESP;
            rvalid_d  = 1'b1;
            rresp_d   = in_range(rd_addr) ? RESP_OKAY : RESP_SLVERR;
            rdata_d   = in_range(rd_addr) ? mem[word_idx(rd_addr)] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_commit && in_range(wr_addr)) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (wr_strb[i]) mem[word_idx(wr_addr)][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_en_q <= 1'b0;
            w_state_q  <= W_IDLE;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= 2'b00;
            r_state_q  <= R_IDLE;
            araddr_q   <= '0;
            cnt_q      <= 4'd0;
            rvalid_q   <= 1'b0;
            rresp_q    <= 2'b00;
            rdata_q    <= '0;
        end else begin
            ready_en_q <= 1'b1;
            w_state_q  <= w_state_d;
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            r_state_q  <= r_state_d;
            araddr_q   <= araddr_d;
            cnt_q      <= cnt_d;
            rvalid_q   <= rvalid_d;
            rresp_q    <= rresp_d;
            rdata_q    <= rdata_d;
        end
    end

endmodule

// File: tb/tb_axi_lite_ram_slave.sv
// Self-checking bench for axi_lite_ram_slave: directed protocol cases plus a
// randomized write/read mix checked against a byte-level memory model.
module tb_axi_lite_ram_slave;

    localparam logic [63:0] BASE = 64'h0000_0000_0002_0000;
    localparam int          MEM  = 4096;
    localparam int          LAT  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] awaddr = '0;
    logic [2:0]  awport = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [63:0] wdata = '0;
    logic [7:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [63:0] araddr = '0;
    logic [2:0]  arport = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;

    int total = 0;
    int bad   = 0;
    logic [63:0] model [int];

    axi_lite_ram_slave #(
        .ADDR_WIDTH(64), .DATA_WIDTH(64), .BASE_ADDR(BASE),
        .MEM_BYTES(MEM), .RD_LATENCY(LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .awaddr(awaddr), .awport(awport), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arport(arport), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: observed no finish, required finish before 2ms");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic bit inRange(input logic [63:0] a);
        return (a >= BASE) && (a < BASE + MEM);
    endfunction

    function automatic int wordOf(input logic [63:0] a);
        return int'((a - BASE) / 8);
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic reportTimeout(input string tag);
        total++;
        bad++;
        $display("[TB] FAIL %s: observed timeout, required handshake within budget", tag);
    endtask

    // Full write transaction; W and AW each raised after their own delay.
    task automatic applyStimulus(input logic [63:0] addr, input logic [63:0] data,
                                 input logic [7:0] strb, input int aw_delay,
                                 input int w_delay, input int b_delay);
        int cyc = 0;
        bit aw_done = 0, w_done = 0, aw_f, w_f;
        logic [1:0] exp_resp;
        exp_resp = inRange(addr) ? 2'b00 : 2'b10;
        @(negedge clk);
        while (!(aw_done && w_done)) begin
            if (cyc > 40) begin
                reportTimeout("write_handshake");
                break;
            end
            awaddr  = addr;
            wdata   = data;
            wstrb   = strb;
            awvalid = !aw_done && (cyc >= aw_delay);
            wvalid  = !w_done && (cyc >= w_delay);
            #1;
            aw_f = awvalid && awready;
            w_f  = wvalid && wready;
            @(posedge clk);
            aw_done = aw_done || aw_f;
            w_done  = w_done || w_f;
            @(negedge clk);
            awvalid = 1'b0;
            wvalid  = 1'b0;
            cyc++;
        end
        checkOutput("b_latency", bvalid, 1'b1);
        checkOutput("bresp", bresp, exp_resp);
        checkOutput("awready_in_resp", awready, 1'b0);
        repeat (b_delay) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("bvalid_hold", bvalid, 1'b1);
            checkOutput("bresp_hold", bresp, exp_resp);
        end
        bready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bready = 1'b0;
        checkOutput("bvalid_clear", bvalid, 1'b0);
        if (inRange(addr)) begin
            logic [63:0] w;
            w = model.exists(wordOf(addr)) ? model[wordOf(addr)] : 64'h0;
            for (int i = 0; i < 8; i++)
                if (strb[i]) w[8*i +: 8] = data[8*i +: 8];
            model[wordOf(addr)] = w;
        end
    endtask

    task automatic applyRead(input logic [63:0] addr, input int rready_delay);
        int cyc;
        logic [63:0] exp_data;
        logic [1:0]  exp_resp;
        exp_data = inRange(addr) ? model[wordOf(addr)] : 64'h0;
        exp_resp = inRange(addr) ? 2'b00 : 2'b10;
        @(negedge clk);
        arvalid = 1'b1;
        araddr  = addr;
        #1;
        checkOutput("arready_idle", arready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        arvalid = 1'b0;
        cyc = 1;
        while (!rvalid && cyc < 40) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        checkOutput("r_latency", 64'(cyc), 64'(LAT + 1));
        checkOutput("rdata", rdata, exp_data);
        checkOutput("rresp", rresp, exp_resp);
        checkOutput("arready_in_resp", arready, 1'b0);
        repeat (rready_delay) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("rvalid_hold", rvalid, 1'b1);
            checkOutput("rdata_hold", rdata, exp_data);
            checkOutput("rresp_hold", rresp, exp_resp);
            checkOutput("arready_hold", arready, 1'b0);
        end
        rready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rready = 1'b0;
        checkOutput("rvalid_clear", rvalid, 1'b0);
        checkOutput("arready_back", arready, 1'b1);
    endtask

    initial begin
        logic [63:0] oldv, newv, a;
        logic [63:0] pool [8];
        bit stale;

        // Reset values while rst is held
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_bvalid", bvalid, 1'b0);
        checkOutput("rst_rvalid", rvalid, 1'b0);
        checkOutput("rst_bresp", bresp, 2'b00);
        checkOutput("rst_rresp", rresp, 2'b00);
        checkOutput("rst_rdata", rdata, 64'h0);
        checkOutput("rst_awready", awready, 1'b0);
        checkOutput("rst_wready", wready, 1'b0);
        checkOutput("rst_arready", arready, 1'b0);
        rst = 1'b0;
        #1;
        checkOutput("post_rst_arready_low", arready, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("first_edge_awready", awready, 1'b1);
        checkOutput("first_edge_arready", arready, 1'b1);

        // Simultaneous AW/W and readback
        applyStimulus(BASE + 8, 64'h1122334455667788, 8'hFF, 0, 0, 0);
        applyRead(BASE + 8, 0);

        // W leading AW by three cycles, low-half strobe over a zero word
        applyStimulus(BASE + 16, 64'h0, 8'hFF, 0, 0, 0);
        applyStimulus(BASE + 16, 64'h1122334455667788, 8'h0F, 3, 0, 0);
        applyRead(BASE + 16, 0);
        checkOutput("strobe_merge", model[wordOf(BASE + 16)], 64'h0000000055667788);

        // Out of range: past the end aliases word 0 if the range check is broken
        applyStimulus(BASE, 64'hA5A5A5A5_5A5A5A5A, 8'hFF, 0, 0, 0);
        applyStimulus(BASE + MEM, 64'hDEADBEEF_CAFEF00D, 8'hFF, 0, 0, 1);
        applyRead(BASE + MEM, 0);
        applyRead(BASE, 0);
        applyRead(BASE - 8, 0);

        // Back-pressured read response
        applyRead(BASE + 8, 5);

        // Write commit on the same edge as the read sample
        oldv = 64'h0BAD_0000_1111_2222;
        newv = 64'h600D_3333_4444_5555;
        applyStimulus(BASE + 24, oldv, 8'hFF, 1, 0, 0);
        @(negedge clk);
        arvalid = 1'b1;
        araddr  = BASE + 24;
        @(posedge clk);
        @(negedge clk);
        arvalid = 1'b0;
        repeat (LAT - 1) begin
            @(posedge clk);
            @(negedge clk);
        end
        awvalid = 1'b1; awaddr = BASE + 24;
        wvalid  = 1'b1; wdata = newv; wstrb = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        awvalid = 1'b0;
        wvalid  = 1'b0;
        checkOutput("coll_rvalid", rvalid, 1'b1);
        checkOutput("coll_old_data", rdata, oldv);
        checkOutput("coll_bvalid", bvalid, 1'b1);
        rready = 1'b1;
        bready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rready = 1'b0;
        bready = 1'b0;
        checkOutput("coll_rvalid_clear", rvalid, 1'b0);
        checkOutput("coll_bvalid_clear", bvalid, 1'b0);
        model[wordOf(BASE + 24)] = newv;
        applyRead(BASE + 24, 0);

        // Randomized mix over a small pool of initialised words
        for (int k = 0; k < 8; k++) begin
            pool[k] = BASE + 64'(8 * (64 + 7 * k));
            applyStimulus(pool[k], {$urandom, $urandom}, 8'hFF, 0, 0, 0);
        end
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                if ($urandom_range(0, 1) == 0) a = BASE + MEM + 64'($urandom_range(0, 4095));
                else a = BASE - 1 - 64'($urandom_range(0, 255));
            end else begin
                a = pool[$urandom_range(0, 7)] + 64'($urandom_range(0, 7));
            end
            if ($urandom_range(0, 1) == 0)
                applyStimulus(a, {$urandom, $urandom}, 8'($urandom_range(0, 255)),
                              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
            else
                applyRead(a, $urandom_range(0, 2));
        end

        // Reset with only the AW beat captured: that write must never land
        @(negedge clk);
        awvalid = 1'b1;
        awaddr  = pool[0];
        @(posedge clk);
        @(negedge clk);
        awvalid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        applyStimulus(pool[1], 64'h7777_8888_9999_AAAA, 8'hFF, 0, 0, 0);
        applyRead(pool[0], 0);
        applyRead(pool[1], 0);

        // Reset asserted while in W_RESP and R_WAIT
        @(negedge clk);
        awvalid = 1'b1; awaddr = BASE + 40;
        wvalid  = 1'b1; wdata = 64'h1234_5678_9ABC_DEF0; wstrb = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        awvalid = 1'b0;
        wvalid  = 1'b0;
        model[wordOf(BASE + 40)] = 64'h1234_5678_9ABC_DEF0;
        checkOutput("pre_rst_bvalid", bvalid, 1'b1);
        arvalid = 1'b1;
        araddr  = BASE + 40;
        @(posedge clk);
        @(negedge clk);
        arvalid = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_bvalid", bvalid, 1'b0);
        checkOutput("async_rst_rvalid", rvalid, 1'b0);
        checkOutput("async_rst_arready", arready, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rel_awready", awready, 1'b1);
        checkOutput("rel_wready", wready, 1'b1);
        checkOutput("rel_arready", arready, 1'b1);
        stale = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bvalid !== 1'b0 || rvalid !== 1'b0) stale = 1'b1;
        end
        checkOutput("no_stale_response", stale, 1'b0);
        applyRead(BASE + 40, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
